// File: rtl/regfile_mp.sv
// regfile_mp: 2-write / NUM_RD-read register file with FSM-driven soft clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     wen1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_req,
  output logic                     busy
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  assign busy = (state_q == CLEAR);
  // Register 0 is never written (writes to 0 are discarded, the clear starts at 1), so it stays zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    if (state_q == IDLE) begin
      if (wen0 && waddr0 != '0) regs_d[waddr0] = wdata0;
      if (wen1 && waddr1 != '0) regs_d[waddr1] = wdata1;
      if (clr_req) begin
        state_d = CLEAR;
        cnt_d   = ADDR_W'(1);
      end
    end else begin
      regs_d[cnt_q] = '0;
      cnt_d         = cnt_q + ADDR_W'(1);
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = IDLE;
        cnt_d   = ADDR_W'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= ADDR_W'(1);
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    assign ra = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    logic fwd0, fwd1;
    assign fwd0 = wen0 && !busy && ra != '0 && waddr0 == ra;
    assign fwd1 = wen1 && !busy && ra != '0 && waddr1 == ra;
    assign rv = fwd1 ? wdata1 : fwd0 ? wdata0 : regs_q[ra];
`else
    assign rv = regs_q[ra];
`endif
    assign rd_data[k*DATA_W +: DATA_W] = (rst && rd_en[k]) ? rv : '0;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp writes, reads, soft clear and reset.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wen0 = 1'b0, wen1 = 1'b0;
  logic [4:0]  waddr0 = '0, waddr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic        clr_req = 1'b0;
  logic        busy;
  int checks = 0;
  int failures = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk(clk), .rst(rst),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .clr_req(clr_req), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rd_en = 2'b11;
    rd_addr = {5'd5, 5'd3};
    wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h12345678;
    #3;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (rd_data !== 64'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", rd_data); end
    tick();
    tick();
    checks++;
    if (rd_data !== 64'h0) begin failures++; $display("FAIL reset_hold_rd got=%h exp=0", rd_data); end
    wen0 = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (rd_data !== 64'h0) begin failures++; $display("FAIL reset_release_rd got=%h exp=0", rd_data); end
  endtask

  task automatic test_basic;
    wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEADBEEF;
    rd_en = 2'b00;
    tick();
    wen0 = 1'b0;
    rd_en = 2'b01;
    rd_addr = {5'd3, 5'd3};
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_rd0 got=%h exp=deadbeef", rd_data[31:0]); end
    checks++;
    if (rd_data[63:32] !== 32'h0) begin failures++; $display("FAIL basic_rd1_disabled got=%h exp=0", rd_data[63:32]); end
    rd_en = 2'b11;
    #1;
    checks++;
    if (rd_data[63:32] !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_rd1 got=%h exp=deadbeef", rd_data[63:32]); end
  endtask

  task automatic test_same_addr;
    rd_en = 2'b00;
    wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111;
    wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22222222;
    tick();
    wen0 = 1'b0;
    waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    tick();
    wen1 = 1'b0;
    rd_en = 2'b11;
    rd_addr = {5'd0, 5'd7};
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h22222222) begin failures++; $display("FAIL same_addr_wd1_wins got=%h exp=22222222", rd_data[31:0]); end
    checks++;
    if (rd_data[63:32] !== 32'h0) begin failures++; $display("FAIL addr0_zero got=%h exp=0", rd_data[63:32]); end
  endtask

  task automatic test_bypass;
    logic [31:0] exp;
    wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h00000001;
    rd_en = 2'b00;
    tick();
    wdata0 = 32'hA5A5A5A5;
    rd_en = 2'b11;
    rd_addr = {5'd0, 5'd9};
    wen1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp = 32'hA5A5A5A5;
`else
    exp = 32'h00000001;
`endif
    checks++;
    if (rd_data[31:0] !== exp) begin failures++; $display("FAIL bypass_rd got=%h exp=%h", rd_data[31:0], exp); end
    checks++;
    if (rd_data[63:32] !== 32'h0) begin failures++; $display("FAIL bypass_addr0 got=%h exp=0", rd_data[63:32]); end
    tick();
    wen0 = 1'b0; wen1 = 1'b0;
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hA5A5A5A5) begin failures++; $display("FAIL commit_rd got=%h exp=a5a5a5a5", rd_data[31:0]); end
    wen0 = 1'b1; wdata0 = 32'h0000000C;
    wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h0000000D;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp = 32'h0000000D;
`else
    exp = 32'hA5A5A5A5;
`endif
    checks++;
    if (rd_data[31:0] !== exp) begin failures++; $display("FAIL bypass_prio got=%h exp=%h", rd_data[31:0], exp); end
    tick();
    wen0 = 1'b0; wen1 = 1'b0;
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h0000000D) begin failures++; $display("FAIL dual_commit got=%h exp=0000000d", rd_data[31:0]); end
  endtask

  task automatic test_clear;
    int c;
    rd_en = 2'b00;
    for (int i = 1; i < 32; i++) begin
      wen0 = 1'b1; waddr0 = 5'(i); wdata0 = 32'h100 | 32'(i);
      tick();
    end
    wen0 = 1'b0;
    rd_en = 2'b11;
    rd_addr = {5'd1, 5'd31};
    #1;
    checks++;
    if (rd_data !== {32'h101, 32'h11F}) begin failures++; $display("FAIL fill_rd got=%h exp=%h", rd_data, {32'h101, 32'h11F}); end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    c = 0;
    while (busy && c < 100) begin
      c++;
      wen0 = (c == 25) || (c == 31);
      waddr0 = (c == 25) ? 5'd20 : 5'd31;
      wdata0 = 32'hBAD0BAD0;
      clr_req = (c == 10);
      #1;
      if (c == 3) begin
        checks++;
        if (rd_data !== {32'h0, 32'h11F}) begin failures++; $display("FAIL clear_mid_rd got=%h exp=%h", rd_data, {32'h0, 32'h11F}); end
      end
      tick();
    end
    wen0 = 1'b0;
    clr_req = 1'b0;
    checks++;
    if (c !== 31) begin failures++; $display("FAIL clear_busy_cycles got=%0d exp=31", c); end
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(31 - i), 5'(i)};
      #1;
      checks++;
      if (rd_data !== 64'h0) begin failures++; $display("FAIL clear_rd addr=%0d got=%h exp=0", i, rd_data); end
    end
  endtask

  task automatic test_reset_mid_clear;
    rd_en = 2'b00;
    wen0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h00001234;
    tick();
    wen0 = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (9) tick();
    rd_en = 2'b01;
    rd_addr = {5'd0, 5'd12};
    #1;
    checks++;
    if (busy !== 1'b1 || rd_data[31:0] !== 32'h00001234) begin
      failures++; $display("FAIL pre_abort busy=%b rd=%h exp busy=1 rd=00001234", busy, rd_data[31:0]);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++;
    if (rd_data !== 64'h0) begin failures++; $display("FAIL abort_rd got=%h exp=0", rd_data); end
    tick();
    rst = 1'b1;
    wen0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h00000044;
    tick();
    wen0 = 1'b0;
    rd_en = 2'b11;
    rd_addr = {5'd12, 5'd4};
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL post_abort_busy got=%b exp=0", busy); end
    checks++;
    if (rd_data !== {32'h0, 32'h44}) begin failures++; $display("FAIL post_abort_rd got=%h exp=%h", rd_data, {32'h0, 32'h44}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_addr();
    test_bypass();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-low.
REQ-006 Port wen0 in 1, waddr0 in ADDR_W, wdata0 in DATA_W; write port 0.
REQ-007 Port wen1 in 1, waddr1 in ADDR_W, wdata1 in DATA_W; write port 1.
REQ-008 Port rd_en  in  NUM_RD  per-port read enable; bit k selects port k.
REQ-009 Port rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-010 Port rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
REQ-011 Port clr_req  in  1  soft-clear request, sampled on a rising edge.
REQ-012 Port busy  out  1  high while a soft clear is in progress.

Function
REQ-013 Register 0 SHALL read as zero always; writes to address 0 discarded.
REQ-014 Writes SHALL commit on the rising edge when wenX=1, the address is nonzero and busy=0.
REQ-015 Both write ports to the same nonzero address in one cycle: wdata1 SHALL win.
REQ-016 Reads SHALL be combinational (zero latency): rd_data[k] = regs[rd_addr[k]] when rd_en[k]=1, else zero.
REQ-017 FSM states SHALL be IDLE and CLEAR; busy = (state == CLEAR).
REQ-018 IDLE->CLEAR on a rising edge with clr_req=1; the clear counter loads 1.
REQ-019 In CLEAR, each cycle SHALL zero regs[counter] and increment the counter.
REQ-020 CLEAR->IDLE on the edge that zeroes index DEPTH-1; a clear occupies exactly DEPTH-1 cycles.
REQ-021 clr_req while busy=1 SHALL be ignored, with no restart and no queuing.
REQ-022 Writes presented while busy=1 SHALL be dropped, including on the final CLEAR cycle.
REQ-023 Reads during CLEAR SHALL return current contents: zero for already-cleared indices, old data otherwise.
REQ-024 Counter arithmetic is ADDR_W bits; completion is detected at DEPTH-1, never by wrap-around.

Reset
REQ-025 rst=0 SHALL immediately force all registers to zero, state IDLE, busy=0 and counter=1, regardless of clk.
REQ-026 rd_data SHALL be all zero while rst=0.
REQ-027 Reset asserted mid-CLEAR SHALL abort the clear; after release the block is in IDLE with all registers zero.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN, when defined, SHALL enable write-to-read forwarding.
  - Forwarding applies when rd_en[k]=1, rd_addr[k] is nonzero, busy=0, and it matches an active write address.
  - rd_data[k] then returns that cycle's write data; wdata1 takes priority over wdata0.
REQ-029 Without REGFILE_BYPASS_EN, reads SHALL return the stored value only; new data is visible the cycle after commit.

Verification
REQ-030 Release reset, wen0=1, waddr0=3, wdata0=0xDEADBEEF; next cycle rd_en[0]=1, rd_addr0=3 -> rd_data0=0xDEADBEEF.
REQ-031 wen0/wen1 both to address 7 with 0x11111111 / 0x22222222 -> regs[7]=0x22222222; wen1 to address 0 with 0xFFFFFFFF -> reading address 0 gives 0.
REQ-032 Same-cycle write of 0xA5A5A5A5 to address 9 while reading 9 (old value 0x1) -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x00000001 without.
REQ-033 Fill all registers, pulse clr_req -> busy high exactly 31 cycles (DEPTH=32); writes dropped and second clr_req ignored during the clear; all reads 0 afterwards.
REQ-034 Assert rst=0 between clock edges mid-CLEAR (counter=10) -> busy=0 and rd_data=0 immediately; after release, IDLE and writes accepted next edge.
